// File: rtl/io_uart_tx_buffer.sv
// rtl/io_uart_tx_buffer.sv - byte FIFO between core output strobe and an 8N1 UART transmitter
// Frames are sent LSB first; a pop on the stop-bit end edge gives back-to-back frames.
module io_uart_tx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_issued,
  input  logic [31:0] out_data,
  output logic        out_stall,
  output logic        txd,
  output logic        tx_busy,
  output logic [31:0] sent_count,
  output logic        overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_txd;
  logic [31:0]       r_sent_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_baud_end;
  logic              w_baud_run;
  logic              w_txd_next;
  logic              w_shift;
  logic              w_frame_done;
  logic [7:0]        w_head;
  logic [23:0]       w_unused_hi;

  assign w_full      = (r_count == COUNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = out_issued && !w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign w_unused_hi = out_data[31:8];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= out_data[7:0];
    end
  end

  // A push while full is dropped even when a pop frees a slot on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (out_issued && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end && (r_bit_idx == 3'd7)) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_next_state = w_empty ? S_IDLE : S_START;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop        = 1'b0;
    w_txd_next   = r_txd;
    w_shift      = 1'b0;
    w_frame_done = 1'b0;
    w_baud_run   = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_txd_next = 1'b1;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_txd_next = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_txd_next = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_shift    = 1'b1;
          w_txd_next = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[1];
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_frame_done = 1'b1;
          w_pop        = !w_empty;
          w_txd_next   = w_empty;
        end
      end
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud       <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_txd        <= 1'b1;
      r_sent_count <= '0;
    end else begin
      r_txd <= w_txd_next;
      if (!w_baud_run || w_baud_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      if (w_pop) begin
        r_shift <= w_head;
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
      end
      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_frame_done) begin
        r_sent_count <= r_sent_count + 1'b1;
      end
    end
  end

  assign out_stall  = w_full;
  assign txd        = r_txd;
  assign tx_busy    = (r_state != S_IDLE);
  assign sent_count = r_sent_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_io_uart_tx_buffer.sv
// tb/tb_io_uart_tx_buffer.sv - self-checking bench for io_uart_tx_buffer
// Reference model schedules whole frames in time; a line monitor decodes received bytes.
module tb_io_uart_tx_buffer;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_issued;
  logic [31:0] out_data;
  logic        out_stall;
  logic        txd;
  logic        tx_busy;
  logic [31:0] sent_count;
  logic        overflow;

  io_uart_tx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .out_issued(out_issued), .out_data(out_data),
    .out_stall(out_stall), .txd(txd), .tx_busy(tx_busy),
    .sent_count(sent_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-schedule model: pending bytes, the frame on the line and its start edge.
  logic [7:0] m_pend[$];
  logic [7:0] acc_log[$];
  logic [7:0] rx_q[$];
  bit         m_act;
  int         m_start;
  logic [7:0] m_byte;
  int         m_sent;
  bit         m_ovf;
  int         cyc = 0;
  bit         chk_model = 0;

  task automatic model_reset();
    m_pend.delete();
    m_act  = 0;
    m_sent = 0;
    m_ovf  = 0;
  endtask

  task automatic model_edge(input logic iss, input logic [7:0] d);
    bit full;
    full = (m_pend.size() == DEPTH);
    if (m_act && (cyc == m_start + 10 * CPB)) begin
      m_sent++;
      m_act = 0;
    end
    if (!m_act && (m_pend.size() != 0)) begin
      m_act   = 1;
      m_start = cyc;
      m_byte  = m_pend.pop_front();
    end
    if (iss) begin
      if (full) begin
        m_ovf = 1;
      end else begin
        m_pend.push_back(d);
        acc_log.push_back(d);
      end
    end
  endtask

  function automatic logic m_txd();
    int k;
    if (!m_act) return 1'b1;
    k = (cyc - m_start) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic tick(input logic iss, input logic [31:0] d);
    out_issued = iss;
    out_data   = d;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_edge(iss, d[7:0]);
    #1;
    if (chk_model) begin
      check($sformatf("model_txd@%0d", cyc), txd, m_txd());
      check($sformatf("model_busy@%0d", cyc), tx_busy, m_act);
      check($sformatf("model_stall@%0d", cyc), out_stall, m_pend.size() == DEPTH);
      check($sformatf("model_sent@%0d", cyc), sent_count, m_sent);
      check($sformatf("model_ovf@%0d", cyc), overflow, m_ovf);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((m_act || m_pend.size() != 0) && n < 3000) begin
      tick(1'b0, 32'h0);
      n++;
    end
    check({name, "_drain_timeout"}, n < 3000, 1);
    repeat (4) tick(1'b0, 32'h0);
  endtask

  // UART line monitor: samples each bit in the middle of its period.
  bit         mon_en = 0;
  int         mon_bad = 0;
  logic [7:0] mon_b;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        repeat (2) @(negedge clk);
        if (txd !== 1'b0) mon_bad++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (txd !== 1'b1) mon_bad++;
        rx_q.push_back(mon_b);
      end
    end
  end

  typedef struct {
    int          first;
    int          last;
    logic        iss;
    logic [31:0] data;
    logic        exp_txd;
    logic        exp_busy;
    int          exp_sent;
  } vec_t;

  vec_t tv[12];

  initial begin
    int pushed;
    int guard;
    tv = '{
      '{0,  0,  1'b1, 32'h123456A5, 1'b1, 1'b0, 0},
      '{1,  4,  1'b0, 32'h0,        1'b0, 1'b1, 0},
      '{5,  8,  1'b0, 32'h0,        1'b1, 1'b1, 0},
      '{9,  12, 1'b0, 32'h0,        1'b0, 1'b1, 0},
      '{13, 16, 1'b0, 32'h0,        1'b1, 1'b1, 0},
      '{17, 20, 1'b0, 32'h0,        1'b0, 1'b1, 0},
      '{21, 24, 1'b0, 32'h0,        1'b0, 1'b1, 0},
      '{25, 28, 1'b0, 32'h0,        1'b1, 1'b1, 0},
      '{29, 32, 1'b0, 32'h0,        1'b0, 1'b1, 0},
      '{33, 36, 1'b0, 32'h0,        1'b1, 1'b1, 0},
      '{37, 40, 1'b0, 32'h0,        1'b1, 1'b1, 0},
      '{41, 45, 1'b0, 32'h0,        1'b1, 1'b0, 1}
    };
    rst        = 1'b0;
    out_issued = 1'b0;
    out_data   = 32'h0;
    model_reset();
    do_reset();
    chk_model = 1;
    check("rst_txd", txd, 1);
    check("rst_stall", out_stall, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_sent", sent_count, 0);
    check("rst_ovf", overflow, 0);

    // Single byte 0xA5
    repeat (3) tick(1'b0, 32'h0);
    foreach (tv[v]) begin
      for (int c = tv[v].first; c <= tv[v].last; c++) begin
        tick(tv[v].iss, tv[v].data);
        check($sformatf("single_txd@%0d", c), txd, tv[v].exp_txd);
        check($sformatf("single_busy@%0d", c), tx_busy, tv[v].exp_busy);
        check($sformatf("single_sent@%0d", c), sent_count, tv[v].exp_sent);
      end
    end

    // Back-to-back 0x00 then 0xFF
    do_reset();
    tick(1'b1, 32'h0000_0000);
    tick(1'b1, 32'h0000_00FF);
    for (int rel = 2; rel <= 85; rel++) begin
      tick(1'b0, 32'h0);
      case (rel)
        36: check("b2b_bit7_zero", txd, 0);
        40: begin check("b2b_stop1", txd, 1); check("b2b_sent40", sent_count, 0); end
        41: begin
          check("b2b_start2", txd, 0);
          check("b2b_busy41", tx_busy, 1);
          check("b2b_sent41", sent_count, 1);
        end
        45: check("b2b_ff_bit0", txd, 1);
        81: begin
          check("b2b_sent81", sent_count, 2);
          check("b2b_idle81", tx_busy, 0);
          check("b2b_txd81", txd, 1);
        end
        default: ;
      endcase
    end

    // Full and overflow, ignoring stall
    do_reset();
    rx_q.delete();
    mon_en = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 32'(i));
      if (i == 15) check("ovf_stall15", out_stall, 0);
      if (i == 16) begin check("ovf_stall16", out_stall, 1); check("ovf_flag16", overflow, 0); end
      if (i == 17) check("ovf_flag17", overflow, 1);
    end
    guard = 0;
    while (sent_count != 17 && guard < 1000) begin
      tick(1'b0, 32'h0);
      guard++;
    end
    check("ovf_wait_timeout", guard < 1000, 1);
    repeat (10) tick(1'b0, 32'h0);
    mon_en = 0;
    check("ovf_sent", sent_count, 17);
    check("ovf_rx_count", rx_q.size(), 17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) check($sformatf("ovf_rx%0d", i), rx_q[i], 8'(i));

    // Push while full on the STOP-end pop edge
    do_reset();
    for (int i = 0; i <= 16; i++) tick(1'b1, 32'h80 + 32'(i));
    for (int e = 17; e <= 40; e++) tick(1'b0, 32'h0);
    check("pf_stall40", out_stall, 1);
    check("pf_ovf40", overflow, 0);
    tick(1'b1, 32'hEE);
    check("pf_ovf41", overflow, 1);
    check("pf_stall41", out_stall, 0);
    check("pf_sent41", sent_count, 1);
    tick(1'b1, 32'hEF);
    check("pf_stall42", out_stall, 1);

    // Reset mid-frame (data bit 3) with 3 bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h5A + 32'(i));
    for (int e = 4; e <= 18; e++) tick(1'b0, 32'h0);
    check("mid_busy18", tx_busy, 1);
    do_reset();
    check("mid_txd", txd, 1);
    check("mid_stall", out_stall, 0);
    check("mid_sent", sent_count, 0);
    check("mid_ovf", overflow, 0);
    check("mid_busy", tx_busy, 0);
    for (int e = 0; e < 100; e++) begin
      tick(1'b0, 32'h0);
      if (txd !== 1'b1 || tx_busy !== 1'b0) check($sformatf("mid_quiet@%0d", e), {txd, tx_busy}, 2'b10);
    end
    check("mid_sent_end", sent_count, 0);

    // Stall-respecting producer, 40 bytes across pointer wrap
    do_reset();
    acc_log.delete();
    rx_q.delete();
    mon_en = 1;
    pushed = 0;
    guard  = 0;
    while (pushed < 40 && guard < 5000) begin
      if (!out_stall && $urandom_range(0, 2) != 0) begin
        tick(1'b1, {24'($urandom), 8'(48 + pushed)});
        pushed++;
      end else begin
        tick(1'b0, $urandom);
      end
      guard++;
    end
    check("wrap_push_timeout", guard < 5000, 1);
    wait_drain("wrap");
    mon_en = 0;
    check("wrap_sent", sent_count, 40);
    check("wrap_ovf", overflow, 0);
    check("wrap_rx_count", rx_q.size(), 40);
    for (int i = 0; i < 40 && i < rx_q.size(); i++) check($sformatf("wrap_rx%0d", i), rx_q[i], 8'(48 + i));

    // Unconstrained random producer, ignoring stall
    do_reset();
    acc_log.delete();
    rx_q.delete();
    mon_en = 1;
    for (int i = 0; i < 800; i++) tick($urandom_range(0, 5) == 0, $urandom);
    wait_drain("rand");
    mon_en = 0;
    check("rand_rx_count", rx_q.size(), acc_log.size());
    for (int i = 0; i < acc_log.size() && i < rx_q.size(); i++) check($sformatf("rand_rx%0d", i), rx_q[i], acc_log[i]);
    check("mon_framing", mon_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
